// File: rtl/video_timing.sv
// ---------------------------------------------------------------------------
// video_timing
//
// Free-running 15 kHz video timing generator for the AY-3-8500 video path.
// A divider turns clk_vid into a one-clock pixel enable.  On each pixel
// enable the horizontal/vertical beam counters step.  The sync, blanking and
// line/frame marker outputs are decoded from the *new* counter values and
// registered on that same edge, so every output changes only together with
// an o_ce_pix high cycle.  The outputs feed the scandoubler's ce_pix, hs_in,
// vs_in, hb_in and vb_in directly.  o_x/o_y drive the game renderer.
//
// Ports
//   i_clk_vid      in   1  video clock, the only clock
//   i_reset        in   1  synchronous, active-high reset
//   o_ce_pix       out  1  one-clock pixel enable, every CE_DIV clocks
//   o_hs           out  1  horizontal sync, active-high
//   o_vs           out  1  vertical sync, active-high
//   o_hb           out  1  horizontal blank
//   o_vb           out  1  vertical blank
//   o_x            out  9  current pixel index, 0..H_TOTAL-1
//   o_y            out  9  current line index, 0..V_TOTAL-1
//   o_line_start   out  1  one-clock pulse on the step where x becomes 0
//   o_frame_start  out  1  one-clock pulse on the step where x and y become 0
// ---------------------------------------------------------------------------
module video_timing #(
  parameter int CE_DIV       = 4,    // clk_vid cycles per pixel, 4..255
  parameter int H_ACTIVE     = 320,  // visible pixels per line
  parameter int H_SYNC_START = 336,  // pixel index where hs rises
  parameter int H_SYNC_LEN   = 32,   // hs width in pixels
  parameter int H_TOTAL      = 400,  // pixels per line, at most 512
  parameter int V_ACTIVE     = 240,  // visible lines
  parameter int V_SYNC_START = 244,  // line index where vs rises
  parameter int V_SYNC_LEN   = 3,    // vs width in lines
  parameter int V_TOTAL      = 262   // lines per frame, at most 512
) (
  input  logic       i_clk_vid,
  input  logic       i_reset,
  output logic       o_ce_pix,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_hb,
  output logic       o_vb,
  output logic [8:0] o_x,
  output logic [8:0] o_y,
  output logic       o_line_start,
  output logic       o_frame_start
);

  // -------------------------------------------------------------------------
  // Parameter legality.  An illegal set stops elaboration with an error; the
  // hardware behaviour for such a set is not defined.
  // -------------------------------------------------------------------------
  if ((CE_DIV < 4) || (CE_DIV > 255) ||
      (H_TOTAL < 1) || (H_TOTAL > 512) ||
      (V_TOTAL < 1) || (V_TOTAL > 512) ||
      (H_ACTIVE > H_SYNC_START) ||
      (V_ACTIVE > V_SYNC_START) ||
      ((H_SYNC_START + H_SYNC_LEN) > H_TOTAL) ||
      ((V_SYNC_START + V_SYNC_LEN) > V_TOTAL)) begin : g_bad_params
    $error("video_timing: illegal timing parameter set");
  end

  // -------------------------------------------------------------------------
  // Constants.  Window bounds are held at 10 bits so that start+len cannot
  // overflow even when the window ends exactly at a 512-entry total.
  // -------------------------------------------------------------------------
  localparam logic [7:0] DIV_LAST  = 8'(CE_DIV - 1);
  localparam logic [8:0] X_LAST    = 9'(H_TOTAL - 1);
  localparam logic [8:0] Y_LAST    = 9'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_10  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_LO_10  = 10'(H_SYNC_START);
  localparam logic [9:0] HS_HI_10  = 10'(H_SYNC_START) + 10'(H_SYNC_LEN);
  localparam logic [9:0] V_ACT_10  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_LO_10  = 10'(V_SYNC_START);
  localparam logic [9:0] VS_HI_10  = 10'(V_SYNC_START) + 10'(V_SYNC_LEN);

  // Unsigned half-open window test: lo <= v < hi.
  function automatic logic f_in_window(
    input logic [9:0] v,
    input logic [9:0] lo,
    input logic [9:0] hi
  );
    f_in_window = (v >= lo) && (v < hi);
  endfunction

  // Unsigned "at or beyond" test used for the blanking decodes.
  function automatic logic f_at_or_above(
    input logic [9:0] v,
    input logic [9:0] lo
  );
    f_at_or_above = (v >= lo);
  endfunction

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  logic [7:0] r_div;
  logic [8:0] r_x;
  logic [8:0] r_y;
  logic       r_ce_pix;
  logic       r_hs;
  logic       r_vs;
  logic       r_hb;
  logic       r_vb;
  logic       r_line_start;
  logic       r_frame_start;

  // -------------------------------------------------------------------------
  // Next-state wires
  // -------------------------------------------------------------------------
  logic       w_step;
  logic       w_x_wrap;
  logic       w_y_wrap;
  logic [8:0] w_x_nxt;
  logic [8:0] w_y_nxt;
  logic       w_hb_nxt;
  logic       w_hs_nxt;
  logic       w_vb_nxt;
  logic       w_vs_nxt;
  logic       w_line_start_nxt;
  logic       w_frame_start_nxt;

  // Pixel-step condition and beam counter successors (used only on a step).
  always_comb begin
    w_step   = (r_div == DIV_LAST);
    w_x_wrap = (r_x == X_LAST);
    w_y_wrap = (r_y == Y_LAST);
    w_x_nxt  = r_x;
    w_y_nxt  = r_y;
    if (w_x_wrap) begin
      w_x_nxt = 9'd0;
      if (w_y_wrap) begin
        w_y_nxt = 9'd0;
      end else begin
        w_y_nxt = r_y + 9'd1;
      end
    end else begin
      w_x_nxt = r_x + 9'd1;
      w_y_nxt = r_y;
    end
  end

  // Status decodes from the post-step beam position.  vb/vs depend only on y,
  // which moves only when x wraps, so they change only on the x==0 step.
  always_comb begin
    w_hb_nxt          = f_at_or_above({1'b0, w_x_nxt}, H_ACT_10);
    w_hs_nxt          = f_in_window({1'b0, w_x_nxt}, HS_LO_10, HS_HI_10);
    w_vb_nxt          = f_at_or_above({1'b0, w_y_nxt}, V_ACT_10);
    w_vs_nxt          = f_in_window({1'b0, w_y_nxt}, VS_LO_10, VS_HI_10);
    w_line_start_nxt  = (w_x_nxt == 9'd0);
    w_frame_start_nxt = (w_x_nxt == 9'd0) && (w_y_nxt == 9'd0);
  end

  // Divider, beam counters and registered outputs.  Reset wins over any step
  // on the same edge.  Between steps the levels hold and the pulses drop.
  always_ff @(posedge i_clk_vid) begin
    if (i_reset) begin
      r_div         <= 8'd0;
      r_x           <= 9'd0;
      r_y           <= 9'd0;
      r_ce_pix      <= 1'b0;
      r_hs          <= 1'b0;
      r_vs          <= 1'b0;
      r_hb          <= 1'b0;
      r_vb          <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_step) begin
      r_div         <= 8'd0;
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_ce_pix      <= 1'b1;
      r_hs          <= w_hs_nxt;
      r_vs          <= w_vs_nxt;
      r_hb          <= w_hb_nxt;
      r_vb          <= w_vb_nxt;
      r_line_start  <= w_line_start_nxt;
      r_frame_start <= w_frame_start_nxt;
    end else begin
      r_div         <= r_div + 8'd1;
      r_ce_pix      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs come straight from registers; no input-to-output paths.
  // -------------------------------------------------------------------------
  assign o_ce_pix      = r_ce_pix;
  assign o_hs          = r_hs;
  assign o_vs          = r_vs;
  assign o_hb          = r_hb;
  assign o_vb          = r_vb;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_video_timing.sv
// ---------------------------------------------------------------------------
// tb_video_timing
//
// Scoreboard bench for video_timing with a reduced raster so that several
// full frames fit in a short run.  The reference model derives every output
// from one number: the count k of clock edges since reset was last sampled
// low (k=0 while in reset).  Pixel number p = k / CE_DIV, beam position is
// p modulo the frame size, and the decodes follow the raster rules directly.
// The stimulus process drives reset (random mid-frame pulses) and pushes the
// expected outputs for each edge; a monitor pops and compares after the edge.
// ---------------------------------------------------------------------------
module tb_video_timing;

  localparam int CE_DIV       = 5;
  localparam int H_ACTIVE     = 20;
  localparam int H_SYNC_START = 28;
  localparam int H_SYNC_LEN   = 4;   // sync ends exactly at the line end
  localparam int H_TOTAL      = 32;
  localparam int V_ACTIVE     = 10;
  localparam int V_SYNC_START = 12;
  localparam int V_SYNC_LEN   = 2;
  localparam int V_TOTAL      = 16;
  localparam int FRAME_CLKS   = CE_DIV * H_TOTAL * V_TOTAL;

  typedef struct packed {
    logic       ce;
    logic       hs;
    logic       vs;
    logic       hb;
    logic       vb;
    logic       ls;
    logic       fs;
    logic [8:0] x;
    logic [8:0] y;
  } obs_t;

  logic       clk;
  logic       reset;
  logic       ce_pix;
  logic       hs;
  logic       vs;
  logic       hb;
  logic       vb;
  logic [8:0] x;
  logic [8:0] y;
  logic       line_start;
  logic       frame_start;

  obs_t        sb_q[$];
  int unsigned k_q[$];
  int unsigned k_model;
  int          n_cmp;
  int          n_err;
  int          n_pushed;
  int          n_popped;

  video_timing #(
    .CE_DIV       (CE_DIV),
    .H_ACTIVE     (H_ACTIVE),
    .H_SYNC_START (H_SYNC_START),
    .H_SYNC_LEN   (H_SYNC_LEN),
    .H_TOTAL      (H_TOTAL),
    .V_ACTIVE     (V_ACTIVE),
    .V_SYNC_START (V_SYNC_START),
    .V_SYNC_LEN   (V_SYNC_LEN),
    .V_TOTAL      (V_TOTAL)
  ) dut (
    .i_clk_vid     (clk),
    .i_reset       (reset),
    .o_ce_pix      (ce_pix),
    .o_hs          (hs),
    .o_vs          (vs),
    .o_hb          (hb),
    .o_vb          (vb),
    .o_x           (x),
    .o_y           (y),
    .o_line_start  (line_start),
    .o_frame_start (frame_start)
  );

  // Clock: period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: outputs after the k-th reset-free edge.
  function automatic obs_t model(input int unsigned k);
    obs_t        e;
    int unsigned p;
    int unsigned pos;
    int unsigned px;
    int unsigned py;
    e = '0;
    if (k != 0) begin
      p   = k / CE_DIV;
      pos = p % (H_TOTAL * V_TOTAL);
      px  = pos % H_TOTAL;
      py  = pos / H_TOTAL;
      e.ce = ((k % CE_DIV) == 0);
      e.x  = px[8:0];
      e.y  = py[8:0];
      e.hb = (px >= H_ACTIVE);
      e.hs = (px >= H_SYNC_START) && (px < H_SYNC_START + H_SYNC_LEN);
      e.vb = (py >= V_ACTIVE);
      e.vs = (py >= V_SYNC_START) && (py < V_SYNC_START + V_SYNC_LEN);
      e.ls = e.ce && (px == 0);
      e.fs = e.ce && (px == 0) && (py == 0);
    end
    return e;
  endfunction

  // One clock of stimulus: set reset for the coming edge and queue the
  // expected outputs for that edge.
  task automatic step(input logic rst);
    @(negedge clk);
    reset = rst;
    if (rst) begin
      k_model = 0;
    end else begin
      k_model = k_model + 1;
    end
    sb_q.push_back(model(k_model));
    k_q.push_back(k_model);
    n_pushed++;
  endtask

  // Monitor: after each active edge, compare the DUT against the oldest
  // queued expectation.
  initial begin
    obs_t        e;
    obs_t        a;
    int unsigned kk;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        kk = k_q.pop_front();
        n_popped++;
        a.ce = ce_pix;
        a.hs = hs;
        a.vs = vs;
        a.hb = hb;
        a.vb = vb;
        a.ls = line_start;
        a.fs = frame_start;
        a.x  = x;
        a.y  = y;
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL outputs k=%0d got ce=%b hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b x=%0d y=%0d expected ce=%b hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b x=%0d y=%0d",
                   kk, a.ce, a.hs, a.vs, a.hb, a.vb, a.ls, a.fs, a.x, a.y,
                   e.ce, e.hs, e.vs, e.hb, e.vb, e.ls, e.fs, e.x, e.y);
        end
      end
    end
  end

  // Watchdog: the run is bounded in time.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  // Stimulus: reset, two full frames plus, random mid-frame resets, a final
  // frame, then drain checks.
  initial begin
    int n;
    int r;
    reset    = 1'b1;
    k_model  = 0;
    n_cmp    = 0;
    n_err    = 0;
    n_pushed = 0;
    n_popped = 0;

    repeat (4) step(1'b1);
    repeat (2 * FRAME_CLKS + 7) step(1'b0);

    for (int i = 0; i < 8; i++) begin
      n = $urandom_range(1, 3000);
      repeat (n) step(1'b0);
      r = (i == 0) ? 1 : $urandom_range(1, 3);
      repeat (r) step(1'b1);
    end

    repeat (FRAME_CLKS + 50) step(1'b0);

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0 || n_popped != n_pushed) begin
      n_err++;
      $display("FAIL drain: got queued=%0d popped=%0d, expected queued=0 popped=%0d",
               sb_q.size(), n_popped, n_pushed);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/video_timing.md
# video_timing

Free-running 15 kHz video timing generator for the AY-3-8500 video path. Divides `clk_vid` into a one-clock pixel enable and runs horizontal/vertical counters, producing registered sync, blanking and beam position. Its `ce_pix`, `hs`, `vs`, `hb` and `vb` feed the scandoubler's `ce_pix`, `hs_in`, `vs_in`, `hb_in` and `vb_in` directly. `x`/`y` drive the game renderer.

## Interface
- `CE_DIV`, 4: `clk_vid` cycles per pixel; legal range 4..255.
- `H_ACTIVE`, 320: visible pixels per line.
- `H_SYNC_START`, 336: pixel index where `hs` rises.
- `H_SYNC_LEN`, 32: `hs` width in pixels.
- `H_TOTAL`, 400: pixels per line; at most 512.
- `V_ACTIVE`, 240: visible lines.
- `V_SYNC_START`, 244: line index where `vs` rises.
- `V_SYNC_LEN`, 3: `vs` width in lines.
- `V_TOTAL`, 262: lines per frame; at most 512.

Ports:
- `clk_vid` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `ce_pix` out 1: one-cycle pixel enable, every `CE_DIV` clocks.
- `hs` out 1: horizontal sync, active-high.
- `vs` out 1: vertical sync, active-high.
- `hb` out 1: horizontal blank.
- `vb` out 1: vertical blank.
- `x` out 9: current pixel index, 0..H_TOTAL-1.
- `y` out 9: current line index, 0..V_TOTAL-1.
- `line_start` out 1: one-cycle pulse when `x` becomes 0.
- `frame_start` out 1: one-cycle pulse when `x` and `y` both become 0.

## Operation
- Divider: `div` is 8 bits and counts 0..CE_DIV-1. On the edge where `div==CE_DIV-1`:
  - `div` returns to 0;
  - `ce_pix` is registered 1;
  - the pixel step below is taken.
- On all other edges `ce_pix` is registered 0.
- Pixel step:
  - `x` advances by 1.
  - When `x==H_TOTAL-1`, `x` returns to 0 and `y` advances by 1; `y` wraps from `V_TOTAL-1` to 0.
  - All status outputs are computed from the new `x`/`y` and registered on the same edge. Every output therefore changes only coincident with a `ce_pix` high cycle.
- Decodes, evaluated on the new values:
  - `hb = x >= H_ACTIVE`
  - `hs = (x >= H_SYNC_START) && (x < H_SYNC_START+H_SYNC_LEN)`
  - `vb = y >= V_ACTIVE`
  - `vs = (y >= V_SYNC_START) && (y < V_SYNC_START+V_SYNC_LEN)`
  - `vs` and `vb` therefore change only on the pixel step that enters `x==0`.
- `line_start` = 1 on a step whose new `x==0`. `frame_start` = 1 on a step whose new `x==0` and new `y==0`. Both are 0 otherwise.
- Comparisons are unsigned. Sums are formed at 10 bits so that `H_SYNC_START+H_SYNC_LEN` cannot overflow.
- Parameter legality: `H_SYNC_START+H_SYNC_LEN <= H_TOTAL`, same rule for V, and `H_ACTIVE <= H_SYNC_START`. Illegal sets are a simulation-time `$error`; hardware behaviour for them is undefined.

## Timing
- Reset is synchronous. While `reset` is high, on every edge:
  - `div=0`, `x=0`, `y=0`;
  - `ce_pix`, `hs`, `vs`, `hb`, `vb`, `line_start` and `frame_start` are all 0.
- Reset asserted mid-line or mid-frame overrides everything on that same edge, with no partial pixel step.
- The first `ce_pix` is at the `CE_DIV`-th edge after the edge on which `reset` was sampled low. That step moves `x` to 1, so `line_start` does not pulse after reset until the first wrap.
- Latency: every output is one register stage behind its decode. There are no combinational paths from input to output.
- `ce_pix` period is exactly `CE_DIV` clocks with a duty of 1 clock; it has no jitter and no gaps, including across line and frame wraps.
- Line period is `H_TOTAL*CE_DIV` clocks. Frame period is `V_TOTAL*H_TOTAL*CE_DIV` clocks.
- The scandoubler requires a constant pixel length inside active video and at least 4 clocks per pixel. Both are met for legal `CE_DIV`.

## Test plan
- **Divider:** defaults, release reset → `ce_pix` high on clocks 4, 8, 12, …; never two highs within 3 clocks; `x` = 1 at the first pulse.
- **Line decode:** defaults → `hb` rises at the `x=320` step and falls at the `x=0` step; `hs` high for exactly 32 `ce_pix` (128 clocks), starting at `x=336`; `line_start` every 1600 clocks.
- **Frame decode:** defaults → `vb` rises when `y=240`, `x=0`; `vs` high for 3 lines (4800 clocks) from `y=244`; `frame_start` every 419200 clocks; `y` wraps 261→0.
- **Reset mid-frame:** assert `reset` for 1 clock at `x=200`, `y=100` → next edge all outputs 0, `x=y=0`; resume as in the divider scenario.
- **Odd divider:** `CE_DIV=5`, `H_TOTAL=400` → `ce_pix` period 5; line period 2000 clocks; `hs` width 160 clocks.
- **Scandoubler pairing:** drive the scandoubler with defaults → its `hs_out` period is 800 clocks, and its `vs_out`/`vb_out` toggle once per frame.
